// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator CPU: default widths, memory
// responder FSM encoding and opcode constants used by the controller.
package acc_pkg;

    localparam int ACC_DATA_W = 8;
    localparam int ACC_ADDR_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_JMP = 4'h5,
        OP_JZ  = 4'h6,
        OP_HLT = 4'hF
    } acc_opcode_t;

endpackage

// File: rtl/acc_mem_array.sv
// Single-port synchronous RAM with registered read; contents are not reset.
module acc_mem_array
    import acc_pkg::*;
#(
    parameter int DATA_W = ACC_DATA_W,
    parameter int ADDR_W = ACC_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // rdata only moves on a read strobe so a completed read stays visible.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/acc_mem_responder.sv
// Fixed-latency memory responder for the multicycle accumulator CPU.
// Optional write protection below PROT_LIMIT: define ACC_MEM_WRITE_PROTECT_EN.
module acc_mem_responder
    import acc_pkg::*;
#(
    parameter int DATA_W     = ACC_DATA_W,
    parameter int ADDR_W     = ACC_ADDR_W,
    parameter int LATENCY    = 2,
    parameter int PROT_LIMIT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              memReady,
    output logic              protErr
);

    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 2);

    mem_state_t        state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              armed_reg, armed_next;
    logic              valid_reg, valid_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              is_write_reg, is_write_next;

    logic              accept, clash, prot_hit;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign accept = (state_reg == IDLE) && armed_reg && (memRead ^ memWrite);
    assign clash  = (state_reg == IDLE) && armed_reg && memRead && memWrite;

`ifdef ACC_MEM_WRITE_PROTECT_EN
    assign prot_hit = is_write_reg && (32'(addr_reg) < 32'(PROT_LIMIT));
`else
    // Every address is writable; the limit is still referenced so the
    // parameter list stays identical in both builds.
    assign prot_hit = 1'b0 & (PROT_LIMIT != 0);
`endif

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        armed_next    = armed_reg;
        valid_next    = valid_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        is_write_next = is_write_reg;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        ram_addr      = addr_reg;
        memReady      = 1'b0;
        protErr       = 1'b0;

        case (state_reg)
            IDLE: begin
                ram_addr = address;
                if (accept) begin
                    addr_next     = address;
                    data_next     = writeData;
                    is_write_next = memWrite;
                    if (LATENCY == 1) begin
                        state_next = DONE;
                        ram_re     = memRead;
                        valid_next = valid_reg | memRead;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = LAT_INIT;
                    end
                end else if (clash) begin
                    protErr    = 1'b1;
                    armed_next = 1'b0;
                end
            end
            WAIT: begin
                // Reads are issued one edge early so data lands in DONE.
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                    ram_re     = !is_write_reg;
                    valid_next = valid_reg | !is_write_reg;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DONE: begin
                memReady   = 1'b1;
                protErr    = prot_hit;
                ram_we     = is_write_reg && !prot_hit;
                armed_next = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (!memRead && !memWrite) begin
            armed_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            armed_reg    <= 1'b1;
            valid_reg    <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            is_write_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            armed_reg    <= armed_next;
            valid_reg    <= valid_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            is_write_reg <= is_write_next;
        end
    end

    // A reset landing on the DONE edge must not commit the pending write.
    acc_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (ram_we && !rst),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (data_reg),
        .rdata (ram_rdata)
    );

    assign readData = valid_reg ? ram_rdata : '0;

endmodule
